// File: rtl/axi_clint_if.sv
// AXI4 single-beat bus bundle between the core's data port and the CLINT.
// Revision 1.0
`default_nettype none

interface axi_clint_if;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_awaddr;
  logic [2:0]  s_awsize;
  logic [3:0]  s_awcache;
  logic [2:0]  s_awprot;
  logic        s_wvalid;
  logic        s_wready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid;
  logic        s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic [2:0]  s_arsize;
  logic [3:0]  s_arcache;
  logic [2:0]  s_arprot;
  logic        s_rvalid;
  logic        s_rready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;

  modport master (
    output s_awvalid, s_awaddr, s_awsize, s_awcache, s_awprot,
    output s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
    output s_arvalid, s_araddr, s_arsize, s_arcache, s_arprot, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_awsize, s_awcache, s_awprot,
    input  s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
    input  s_arvalid, s_araddr, s_arsize, s_arcache, s_arprot, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast
  );
endinterface

`default_nettype wire

// File: rtl/axi_clint.sv
// =====================================================================
// axi_clint : AXI4 single-beat CLINT (msip, mtimecmp, mtime) for one hart
// Revision  : 1.0
// =====================================================================
`default_nettype none

module axi_clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        reset,
  axi_clint_if.slave  bus,
  output logic [63:0] mtime,
  output logic        timer_intr,
  output logic        software_intr
);
  localparam logic [1:0]  c_sel_none  = 2'd0;
  localparam logic [1:0]  c_sel_msip  = 2'd1;
  localparam logic [1:0]  c_sel_cmp   = 2'd2;
  localparam logic [1:0]  c_sel_time  = 2'd3;
  localparam logic [1:0]  c_okay      = 2'b00;
  localparam logic [1:0]  c_slverr    = 2'b10;
  localparam logic [15:0] c_presc_max = 16'(TICK_DIV - 1);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} rstate_t;

  // BASE_ADDR is 64 KiB aligned, so only doubleword address bits matter.
  function automatic logic [1:0] decode(input logic [28:0] dw_addr);
    logic [28:0] off;
    off = dw_addr - BASE_ADDR[31:3];
    decode = c_sel_none;
    if (off[28:13] == 16'h0000) begin
      case (off[12:0])
        13'h0000: decode = c_sel_msip;
        13'h0800: decode = c_sel_cmp;
        13'h17FF: decode = c_sel_time;
        default:  decode = c_sel_none;
      endcase
    end
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] strb);
    logic [63:0] res;
    for (int i = 0; i < 8; i++)
      res[8*i +: 8] = strb[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return res;
  endfunction

  wstate_t     r_wstate, w_wstate_nxt;
  rstate_t     r_rstate, w_rstate_nxt;
  logic        r_aw_held, r_w_held, w_aw_held_nxt, w_w_held_nxt;
  logic        r_awready, r_wready, r_arready;
  logic        w_awready_nxt, w_wready_nxt, w_arready_nxt;
  logic [28:0] r_awaddr, w_waddr;
  logic [63:0] r_wdata, w_wdata;
  logic [7:0]  r_wstrb, w_wstrb;
  logic [1:0]  r_bresp, w_bresp_nxt, r_rresp, w_wsel, w_rsel;
  logic [63:0] r_rdata, w_rdata_nxt;
  logic        w_aw_fire, w_w_fire, w_ar_fire, w_commit, w_tick;
  logic        r_msip, r_timer, r_soft;
  logic [63:0] r_mtimecmp, r_mtime;
  logic [15:0] r_presc;
  logic        w_unused;

  assign w_unused = ^{bus.s_awsize, bus.s_awcache, bus.s_awprot, bus.s_arsize,
                      bus.s_arcache, bus.s_arprot, bus.s_wlast,
                      bus.s_awaddr[2:0], bus.s_araddr[2:0]};

  assign w_aw_fire = bus.s_awvalid & r_awready;
  assign w_w_fire  = bus.s_wvalid & r_wready;
  assign w_ar_fire = bus.s_arvalid & r_arready;
  assign w_waddr   = r_aw_held ? r_awaddr : bus.s_awaddr[31:3];
  assign w_wdata   = r_w_held ? r_wdata : bus.s_wdata;
  assign w_wstrb   = r_w_held ? r_wstrb : bus.s_wstrb;
  assign w_wsel    = decode(w_waddr);
  assign w_rsel    = decode(bus.s_araddr[31:3]);
  assign w_commit  = (r_wstate == W_IDLE) & (r_aw_held | w_aw_fire) & (r_w_held | w_w_fire);
  assign w_tick    = (r_presc == c_presc_max);

  // Readies are registered from next-state values so they are low in reset.
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_aw_held_nxt = r_aw_held;
    w_w_held_nxt  = r_w_held;
    w_bresp_nxt   = r_bresp;
    case (r_wstate)
      W_IDLE: begin
        w_aw_held_nxt = r_aw_held | w_aw_fire;
        w_w_held_nxt  = r_w_held | w_w_fire;
        if (w_commit) begin
          w_wstate_nxt = W_RESP;
          w_bresp_nxt  = (w_wsel == c_sel_none) ? c_slverr : c_okay;
        end
      end
      W_RESP: begin
        if (bus.s_bready) begin
          w_wstate_nxt  = W_IDLE;
          w_aw_held_nxt = 1'b0;
          w_w_held_nxt  = 1'b0;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
    w_awready_nxt = (w_wstate_nxt == W_IDLE) & ~w_aw_held_nxt;
    w_wready_nxt  = (w_wstate_nxt == W_IDLE) & ~w_w_held_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_fire) w_rstate_nxt = R_RESP;
      R_RESP:  if (bus.s_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
    w_arready_nxt = (w_rstate_nxt == R_IDLE);
    case (w_rsel)
      c_sel_msip: w_rdata_nxt = {63'd0, r_msip};
      c_sel_cmp:  w_rdata_nxt = r_mtimecmp;
      c_sel_time: w_rdata_nxt = r_mtime;
      default:    w_rdata_nxt = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wstate  <= W_IDLE;
      r_rstate  <= R_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= c_okay;
      r_rresp   <= c_okay;
      r_rdata   <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_rstate  <= w_rstate_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_arready <= w_arready_nxt;
      r_bresp   <= w_bresp_nxt;
      if (w_aw_fire) r_awaddr <= bus.s_awaddr[31:3];
      if (w_w_fire) begin
        r_wdata <= bus.s_wdata;
        r_wstrb <= bus.s_wstrb;
      end
      if (w_ar_fire) begin
        r_rdata <= w_rdata_nxt;
        r_rresp <= (w_rsel == c_sel_none) ? c_slverr : c_okay;
      end
    end
  end

  // A committed mtime write replaces that cycle's increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc    <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      r_timer    <= 1'b0;
      r_soft     <= 1'b0;
    end else begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      if (w_commit && w_wsel == c_sel_time)
        r_mtime <= merge(r_mtime, w_wdata, w_wstrb);
      else if (w_tick)
        r_mtime <= r_mtime + 64'd1;
      if (w_commit && w_wsel == c_sel_cmp)
        r_mtimecmp <= merge(r_mtimecmp, w_wdata, w_wstrb);
      if (w_commit && w_wsel == c_sel_msip && w_wstrb[0])
        r_msip <= w_wdata[0];
      r_timer <= (r_mtime >= r_mtimecmp);
      r_soft  <= r_msip;
    end
  end

  assign bus.s_awready = r_awready;
  assign bus.s_wready  = r_wready;
  assign bus.s_arready = r_arready;
  assign bus.s_bvalid  = (r_wstate == W_RESP);
  assign bus.s_bresp   = r_bresp;
  assign bus.s_rvalid  = (r_rstate == R_RESP);
  assign bus.s_rlast   = (r_rstate == R_RESP);
  assign bus.s_rresp   = r_rresp;
  assign bus.s_rdata   = r_rdata;
  assign mtime         = r_mtime;
  assign timer_intr    = r_timer;
  assign software_intr = r_soft;
endmodule

`default_nettype wire

// File: tb/tb_axi_clint.sv
// Directed bench for axi_clint: one instance at TICK_DIV=1, one at TICK_DIV=4.
// Revision 1.0
`default_nettype none

module tb_axi_clint;
  localparam logic [31:0] c_base = 32'h0200_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  axi_clint_if bus1();
  axi_clint_if bus4();
  logic [63:0] mtime1, mtime4;
  logic        timer1, timer4, sw1, sw4;

  axi_clint #(.BASE_ADDR(c_base), .TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .mtime(mtime1), .timer_intr(timer1), .software_intr(sw1));

  axi_clint #(.BASE_ADDR(c_base), .TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4),
    .mtime(mtime4), .timer_intr(timer4), .software_intr(sw4));

  assign bus1.s_awsize = 3'd3; assign bus1.s_awcache = 4'd0; assign bus1.s_awprot = 3'd0;
  assign bus1.s_arsize = 3'd3; assign bus1.s_arcache = 4'd0; assign bus1.s_arprot = 3'd0;
  assign bus1.s_wlast  = 1'b1;
  assign bus4.s_awsize = 3'd3; assign bus4.s_awcache = 4'd0; assign bus4.s_awprot = 3'd0;
  assign bus4.s_arsize = 3'd3; assign bus4.s_arcache = 4'd0; assign bus4.s_arprot = 3'd0;
  assign bus4.s_wlast  = 1'b1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, output logic [1:0] resp);
    logic aw_pend, w_pend, aw_hs, w_hs, got;
    bus1.s_awaddr = addr; bus1.s_wdata = data; bus1.s_wstrb = strb;
    bus1.s_awvalid = 1'b1; bus1.s_wvalid = 1'b1;
    aw_pend = 1'b1; w_pend = 1'b1;
    for (int i = 0; i < 40 && (aw_pend || w_pend); i++) begin
      aw_hs = bus1.s_awvalid && bus1.s_awready;
      w_hs  = bus1.s_wvalid && bus1.s_wready;
      @(posedge clk); #1;
      if (aw_hs) begin bus1.s_awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_hs)  begin bus1.s_wvalid  = 1'b0; w_pend  = 1'b0; end
    end
    check("write_accepted_pending", {62'd0, aw_pend, w_pend}, 64'd0);
    bus1.s_awvalid = 1'b0; bus1.s_wvalid = 1'b0;
    bus1.s_bready = 1'b1; got = 1'b0; resp = 2'b11;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus1.s_bvalid) begin got = 1'b1; resp = bus1.s_bresp; end
      @(posedge clk); #1;
    end
    bus1.s_bready = 1'b0;
    check("write_response_seen", {63'd0, got}, 64'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [63:0] data,
                          output logic [1:0] resp);
    logic ar_hs, done, got;
    bus1.s_araddr = addr; bus1.s_arvalid = 1'b1; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      ar_hs = bus1.s_arvalid && bus1.s_arready;
      @(posedge clk); #1;
      if (ar_hs) done = 1'b1;
    end
    bus1.s_arvalid = 1'b0;
    check("read_addr_accepted", {63'd0, done}, 64'd1);
    bus1.s_rready = 1'b1; got = 1'b0; data = '1; resp = 2'b11;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus1.s_rvalid) begin
        got = 1'b1; data = bus1.s_rdata; resp = bus1.s_rresp;
        check("rlast_eq_rvalid", {63'd0, bus1.s_rlast}, 64'd1);
      end
      @(posedge clk); #1;
    end
    bus1.s_rready = 1'b0;
    check("read_response_seen", {63'd0, got}, 64'd1);
  endtask

  logic [1:0]  resp, rr;
  logic [63:0] rd;
  logic        seen21, hs;

  initial begin
    bus1.s_awvalid = 0; bus1.s_wvalid = 0; bus1.s_arvalid = 0; bus1.s_bready = 0; bus1.s_rready = 0;
    bus1.s_awaddr = 0; bus1.s_wdata = 0; bus1.s_wstrb = 0; bus1.s_araddr = 0;
    bus4.s_awvalid = 0; bus4.s_wvalid = 0; bus4.s_arvalid = 0; bus4.s_bready = 0; bus4.s_rready = 0;
    bus4.s_awaddr = 0; bus4.s_wdata = 0; bus4.s_wstrb = 0; bus4.s_araddr = 0;

    // Reset values
    repeat (2) @(posedge clk); #1;
    check("reset_readies", {61'd0, bus1.s_awready, bus1.s_wready, bus1.s_arready}, 64'd0);
    check("reset_valids", {61'd0, bus1.s_bvalid, bus1.s_rvalid, bus1.s_rlast}, 64'd0);
    check("reset_resps", {60'd0, bus1.s_bresp, bus1.s_rresp}, 64'd0);
    check("reset_rdata", bus1.s_rdata, 64'd0);
    check("reset_mtime", mtime1, 64'd0);
    check("reset_intrs", {62'd0, timer1, sw1}, 64'd0);

    // Idle count, then asynchronous reset mid-count
    reset = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("idle10_mtime", mtime1, 64'd10);
    check("idle10_mtime_div4", mtime4, 64'd2);
    check("idle10_timer", {63'd0, timer1}, 64'd0);
    check("idle10_valids", {62'd0, bus1.s_bvalid, bus1.s_rvalid}, 64'd0);
    check("idle10_readies", {61'd0, bus1.s_awready, bus1.s_wready, bus1.s_arready}, 64'd7);
    #2; reset = 1'b0; #1;
    check("async_reset_mtime", mtime1, 64'd0);
    check("async_reset_arready", {63'd0, bus1.s_arready}, 64'd0);
    @(posedge clk); #1; reset = 1'b1;

    // mtimecmp = 20 and timer edge
    axi_write(c_base + 32'h4000, 64'd20, 8'hFF, resp);
    check("cmp_bresp", {62'd0, resp}, 64'd0);
    seen21 = 1'b0;
    for (int i = 0; i < 60 && !seen21; i++) begin
      @(posedge clk); #1;
      if (mtime1 == 64'd20) check("timer_at_mtime20", {63'd0, timer1}, 64'd0);
      if (mtime1 == 64'd21) begin
        check("timer_at_mtime21", {63'd0, timer1}, 64'd1);
        seen21 = 1'b1;
      end
    end
    check("mtime_reached_21", {63'd0, seen21}, 64'd1);
    repeat (3) @(posedge clk); #1;
    check("timer_stays_high", {63'd0, timer1}, 64'd1);

    // msip
    axi_write(c_base, 64'h1, 8'h01, resp);
    check("msip_bresp", {62'd0, resp}, 64'd0);
    check("msip_swi_high", {63'd0, sw1}, 64'd1);
    axi_read(c_base, rd, rr);
    check("msip_rdata", rd, 64'd1);
    check("msip_rresp", {62'd0, rr}, 64'd0);
    axi_write(c_base, 64'h0, 8'h01, resp);
    check("msip_swi_low", {63'd0, sw1}, 64'd0);

    // W before AW, delayed bready
    reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
    bus1.s_wdata = 64'hDEAD_BEEF; bus1.s_wstrb = 8'h0F; bus1.s_wvalid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 10 && !hs; i++) begin
      hs = bus1.s_wready;
      @(posedge clk); #1;
    end
    bus1.s_wvalid = 1'b0;
    check("wfirst_w_accepted", {63'd0, hs}, 64'd1);
    repeat (3) @(posedge clk); #1;
    check("wfirst_wready_held_bvalid", {62'd0, bus1.s_wready, bus1.s_bvalid}, 64'd0);
    bus1.s_awaddr = c_base + 32'h4000; bus1.s_awvalid = 1'b1; bus1.s_bready = 1'b0;
    hs = 1'b0;
    for (int i = 0; i < 10 && !hs; i++) begin
      hs = bus1.s_awready;
      @(posedge clk); #1;
    end
    bus1.s_awvalid = 1'b0;
    check("wfirst_aw_accepted", {63'd0, hs}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("wfirst_bvalid_held", {59'd0, bus1.s_bvalid, bus1.s_bresp, bus1.s_awready, bus1.s_wready},
            64'h10);
      @(posedge clk); #1;
    end
    bus1.s_bready = 1'b1;
    check("wfirst_bvalid_before_ready", {63'd0, bus1.s_bvalid}, 64'd1);
    @(posedge clk); #1;
    bus1.s_bready = 1'b0;
    check("wfirst_bvalid_dropped", {63'd0, bus1.s_bvalid}, 64'd0);
    @(posedge clk); #1;
    check("wfirst_readies_back", {62'd0, bus1.s_awready, bus1.s_wready}, 64'd3);
    axi_read(c_base + 32'h4000, rd, rr);
    check("wfirst_mtimecmp", rd, 64'hFFFF_FFFF_DEAD_BEEF);

    // Unmapped and out-of-window accesses
    axi_read(c_base + 32'h8000, rd, rr);
    check("unmapped_rdata", rd, 64'd0);
    check("unmapped_rresp", {62'd0, rr}, 64'd2);
    axi_write(c_base + 32'h1_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp);
    check("oow_bresp", {62'd0, resp}, 64'd2);
    axi_read(c_base + 32'h4000, rd, rr);
    check("oow_mtimecmp_kept", rd, 64'hFFFF_FFFF_DEAD_BEEF);
    axi_read(c_base, rd, rr);
    check("oow_msip_kept", rd, 64'd0);
    check("oow_swi_low", {63'd0, sw1}, 64'd0);

    // TICK_DIV=4: mtime write on increment edge with concurrent read
    reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
    repeat (7) @(posedge clk); #1;
    check("div4_mtime_edge7", mtime4, 64'd1);
    bus4.s_awaddr = c_base + 32'hBFF8; bus4.s_wdata = 64'hFFFF_FFFF_FFFF_FFFE; bus4.s_wstrb = 8'hFF;
    bus4.s_araddr = c_base + 32'hBFF8;
    bus4.s_awvalid = 1'b1; bus4.s_wvalid = 1'b1; bus4.s_arvalid = 1'b1;
    check("div4_readies", {61'd0, bus4.s_awready, bus4.s_wready, bus4.s_arready}, 64'd7);
    @(posedge clk); #1;
    bus4.s_awvalid = 1'b0; bus4.s_wvalid = 1'b0; bus4.s_arvalid = 1'b0;
    check("div4_write_wins", mtime4, 64'hFFFF_FFFF_FFFF_FFFE);
    check("div4_bresp", {61'd0, bus4.s_bvalid, bus4.s_bresp}, 64'h4);
    check("div4_rresp", {60'd0, bus4.s_rvalid, bus4.s_rlast, bus4.s_rresp}, 64'hC);
    check("div4_read_old", bus4.s_rdata, 64'd1);
    bus4.s_bready = 1'b1; bus4.s_rready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("div4_mtime_edge11", mtime4, 64'hFFFF_FFFF_FFFF_FFFE);
    check("div4_resp_done", {62'd0, bus4.s_bvalid, bus4.s_rvalid}, 64'd0);
    @(posedge clk); #1;
    check("div4_mtime_edge12", mtime4, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (4) @(posedge clk); #1;
    check("div4_mtime_wrap", mtime4, 64'd0);
    check("div4_timer_at_max", {63'd0, timer4}, 64'd1);
    @(posedge clk); #1;
    check("div4_timer_after_wrap", {63'd0, timer4}, 64'd0);
    bus4.s_bready = 1'b0; bus4.s_rready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
